// File: rtl/rv_pkg.sv
// Shared RV64 integer register file types and sizes.
package rv_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;
endpackage

// File: rtl/rf_multiport_if.sv
// Decode/writeback-facing bus of the multi-port register file; ports are flattened, port k at [k*W +: W].
interface rf_multiport_if #(
    parameter int NRD = 2,
    parameter int NWR = 1
);
    import rv_pkg::*;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    reg_addr_t           alloc_addr;
    logic                flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: write clears, alloc sets, flush clears all; same-cycle write clear is bypassed to rd_busy.
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int NRD = 2,
    parameter int NWR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              alloc_en,
    input  reg_addr_t         alloc_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy, busy_nx, wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p]) wr_hit[wr_addr[p*AW +: AW]] = 1'b1;
        busy_nx = busy & ~wr_hit;
        // A new producer supersedes the completing one; flush overrides everything.
        if (alloc_en) busy_nx[alloc_addr] = 1'b1;
        if (flush)    busy_nx = '0;
        busy_nx[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nx;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_busy
        reg_addr_t a;
        assign a          = rd_addr[k*AW +: AW];
        assign rd_busy[k] = ~rst & busy[a] & ~wr_hit[a];
    end
endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file: hardwired-zero x0, fixed-priority writes (highest port wins), write-first read bypass.
module rf_multiport
    import rv_pkg::*;
#(
    parameter int NRD = 2,
    parameter int NWR = 1
) (
    input  logic          clk,
    input  logic          rst,
    rf_multiport_if.slave bus
);
    xdata_t regs [NREGS];

    // Later ports are applied last so they win on an address conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] != '0)
                    regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        reg_addr_t a;
        xdata_t    d;
        assign a = bus.rd_addr[k*AW +: AW];
        always_comb begin
            d = regs[a];
            for (int p = 0; p < NWR; p++)
                if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] == a)
                    d = bus.wr_data[p*XLEN +: XLEN];
            if (rst || a == '0) d = '0;
        end
        assign bus.rd_data[k*XLEN +: XLEN] = d;
    end

    rf_scoreboard #(.NRD(NRD), .NWR(NWR)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .rd_addr    (bus.rd_addr),
        .rd_busy    (bus.rd_busy)
    );
endmodule
